uar_rx_ctrl: RTL and testbench

UAR_RX_CTRL -- requirements
Module: uar_rx_ctrl

---
 rtl/uar_pkg.sv | 21 ++
 rtl/uar_synchro.sv | 25 ++
 rtl/uar_rx_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_uar_rx_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uar_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e      - receiver FSM state encoding
//   OVERSAMPLE_DEF  - default BaudTick pulses per bit
//   DATA_BITS_DEF   - default data bits per frame
// Optional feature macro: UAR_RX_PARITY_EN adds the parity state.
package uar_pkg;

   localparam int unsigned OVERSAMPLE_DEF = 16;
   localparam int unsigned DATA_BITS_DEF  = 8;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
`ifdef UAR_RX_PARITY_EN
      StParity,
`endif
      StStop
   } rx_state_e;

endpackage

// File: rtl/uar_synchro.sv
// Two-flop synchronizer for a single asynchronous level, reset to 1 (idle line).
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   din   - asynchronous input
//   dout  - synchronized output
module uar_synchro (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         dout   <= 1'b1;
      end else begin
         meta_q <= din;
         dout   <= meta_q;
      end
   end

endmodule

// File: rtl/uar_rx_ctrl.sv
// UART receive controller: oversampled start detection, mid-bit sampling, LSB-first
// shift register, one-word holding register with overrun and framing error pulses.
// Ports:
//   Clk, Rst_n          - clock, asynchronous active-low reset
//   RxEn                - receiver enable; low aborts any frame in progress
//   BaudTick            - one-Clk pulse at OVERSAMPLE x baud; all FSM activity gated by it
//   RxAsync             - raw serial line (idle high)
//   RxRead              - consumer has taken RxData
//   RxData, RxValid     - received word and its unread flag
//   FrameErr            - one-Clk pulse, stop bit sampled low
//   ParityErr           - one-Clk pulse, even-parity mismatch (UAR_RX_PARITY_EN only)
//   OverrunErr          - one-Clk pulse, word completed while RxValid was high
// Optional feature macro: UAR_RX_PARITY_EN.
module uar_rx_ctrl
   import uar_pkg::*;
#(
   parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 RxEn,
   input  logic                 BaudTick,
   input  logic                 RxAsync,
   input  logic                 RxRead,
   output logic [DATA_BITS-1:0] RxData,
   output logic                 RxValid,
   output logic                 FrameErr,
`ifdef UAR_RX_PARITY_EN
   output logic                 ParityErr,
`endif
   output logic                 OverrunErr
);

   localparam int unsigned TickW = $clog2(OVERSAMPLE);
   localparam int unsigned BitW  = $clog2(DATA_BITS);
   localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
   localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

   logic                 sync_rx;
   logic                 prev_rx_q;
   rx_state_e            state_q, state_d;
   logic [TickW-1:0]     tick_q, tick_d;
   logic [BitW-1:0]      bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 word_done, frame_err_d;
`ifdef UAR_RX_PARITY_EN
   logic                 par_err_q, par_err_d;
   logic                 parity_err_d;
`endif

   uar_synchro u_synchro (
      .clk   (Clk),
      .rst_n (Rst_n),
      .din   (RxAsync),
      .dout  (sync_rx)
   );

   // State register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q   <= StIdle;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         prev_rx_q <= 1'b1;
`ifdef UAR_RX_PARITY_EN
         par_err_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
`ifdef UAR_RX_PARITY_EN
         par_err_q <= par_err_d;
`endif
         // Start detection needs the line level seen at the previous tick.
         if (BaudTick) prev_rx_q <= sync_rx;
      end
   end

   // Next state and counters
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
`ifdef UAR_RX_PARITY_EN
      par_err_d = par_err_q;
`endif
      if (!RxEn) begin
         state_d = StIdle;
         tick_d  = '0;
         bit_d   = '0;
      end else if (BaudTick) begin
         tick_d = (tick_q == TickLast) ? '0 : tick_q + 1'b1;
         case (state_q)
            StIdle: begin
               tick_d = '0;
               bit_d  = '0;
               if (!sync_rx && prev_rx_q) state_d = StStart;
            end
            StStart: begin
               if (tick_q == TickMid) begin
                  tick_d  = '0;
                  state_d = sync_rx ? StIdle : StData;
               end
            end
            StData: begin
               if (tick_q == TickLast) begin
                  shift_d = {sync_rx, shift_q[DATA_BITS-1:1]};
                  if (bit_q == BitLast) begin
                     bit_d = '0;
`ifdef UAR_RX_PARITY_EN
                     state_d = StParity;
`else
                     state_d = StStop;
`endif
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end
`ifdef UAR_RX_PARITY_EN
            StParity: begin
               if (tick_q == TickLast) begin
                  // Even parity: data ones plus parity bit must be even.
                  par_err_d = ^{shift_q, sync_rx};
                  state_d   = StStop;
               end
            end
`endif
            StStop: begin
               if (tick_q == TickLast) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // Stop-bit outcome; a low stop bit takes precedence over a parity mismatch.
   always_comb begin
      word_done   = 1'b0;
      frame_err_d = 1'b0;
`ifdef UAR_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
      if (RxEn && BaudTick && (state_q == StStop) && (tick_q == TickLast)) begin
         if (!sync_rx) begin
            frame_err_d = 1'b1;
`ifdef UAR_RX_PARITY_EN
         end else if (par_err_q) begin
            parity_err_d = 1'b1;
`endif
         end else begin
            word_done = 1'b1;
         end
      end
   end

   // Holding register and error pulses
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         RxData     <= '0;
         RxValid    <= 1'b0;
         FrameErr   <= 1'b0;
         OverrunErr <= 1'b0;
`ifdef UAR_RX_PARITY_EN
         ParityErr  <= 1'b0;
`endif
      end else begin
         FrameErr   <= frame_err_d;
         OverrunErr <= 1'b0;
`ifdef UAR_RX_PARITY_EN
         ParityErr  <= parity_err_d;
`endif
         // A read in the same cycle frees the register, so the new word is not an overrun.
         if (word_done && (!RxValid || RxRead)) begin
            RxData  <= shift_q;
            RxValid <= 1'b1;
         end else begin
            if (word_done) OverrunErr <= 1'b1;
            if (RxRead)    RxValid    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uar_rx_ctrl.sv
module tb_uar_rx_ctrl;

   logic       Clk = 1'b0;
   logic       Rst_n;
   logic       RxEn;
   logic       BaudTick;
   logic       RxAsync;
   logic       RxRead;
   logic [7:0] RxData;
   logic       RxValid;
   logic       FrameErr;
   logic       OverrunErr;
`ifdef UAR_RX_PARITY_EN
   logic       ParityErr;
`endif

   int checks   = 0;
   int failures = 0;
   int fe_cnt   = 0;
   int ov_cnt   = 0;
   int pe_cnt   = 0;

   always #5 Clk = ~Clk;

   uar_rx_ctrl #(
      .OVERSAMPLE (16),
      .DATA_BITS  (8)
   ) dut (
      .Clk        (Clk),
      .Rst_n      (Rst_n),
      .RxEn       (RxEn),
      .BaudTick   (BaudTick),
      .RxAsync    (RxAsync),
      .RxRead     (RxRead),
      .RxData     (RxData),
      .RxValid    (RxValid),
      .FrameErr   (FrameErr),
`ifdef UAR_RX_PARITY_EN
      .ParityErr  (ParityErr),
`endif
      .OverrunErr (OverrunErr)
   );

   // Pulse-cycle counters, sampled away from the active edge.
   always @(negedge Clk) begin
      if (FrameErr === 1'b1)   fe_cnt++;
      if (OverrunErr === 1'b1) ov_cnt++;
`ifdef UAR_RX_PARITY_EN
      if (ParityErr === 1'b1)  pe_cnt++;
`endif
   end

   // One BaudTick period: tick high for one Clk, then three idle Clks. Called at a negedge.
   task automatic tick_cycle();
      BaudTick = 1'b1;
      @(negedge Clk);
      BaudTick = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic send_bit(input logic b);
      RxAsync = b;
      repeat (16) tick_cycle();
   endtask

   // Full frame. With the line changing together with a tick, the receiver detects the
   // start edge one tick later, so every bit is sampled on tick 9 of its 16.
   // v_before/v_after: RxValid just before / just after the stop-sampling tick edge.
   task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop,
                             input logic read_at_done, input int stall_clks,
                             output logic v_before, output logic v_after);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         send_bit(data[i]);
         if (i == 4 && stall_clks > 0) repeat (stall_clks) @(negedge Clk);
      end
`ifdef UAR_RX_PARITY_EN
      send_bit((^data) ^ par_flip);
`endif
      RxAsync = stop;
      repeat (9) tick_cycle();
      v_before = RxValid;
      BaudTick = 1'b1;
      RxRead   = read_at_done;
      @(negedge Clk);
      BaudTick = 1'b0;
      RxRead   = 1'b0;
      v_after  = RxValid;
      repeat (3) @(negedge Clk);
      repeat (6) tick_cycle();
      RxAsync = 1'b1;
      repeat (4) tick_cycle();
   endtask

   task automatic read_pulse();
      RxRead = 1'b1;
      @(negedge Clk);
      RxRead = 1'b0;
   endtask

   task automatic test_reset();
      Rst_n = 1'b0;
      repeat (3) @(negedge Clk);
      checks++; if (RxValid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", RxValid); end
      checks++; if (RxData !== 8'h00) begin failures++; $display("FAIL reset_data got %h want 00", RxData); end
      checks++; if (FrameErr !== 1'b0) begin failures++; $display("FAIL reset_ferr got %b want 0", FrameErr); end
      checks++; if (OverrunErr !== 1'b0) begin failures++; $display("FAIL reset_oerr got %b want 0", OverrunErr); end
      Rst_n = 1'b1;
      repeat (4) tick_cycle();
   endtask

   task automatic test_good_frame();
      logic vb, va;
      int fe0, ov0;
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 0, vb, va);
      checks++; if (vb !== 1'b0) begin failures++; $display("FAIL a5_valid_early got %b want 0", vb); end
      checks++; if (va !== 1'b1) begin failures++; $display("FAIL a5_valid_next got %b want 1", va); end
      checks++; if (RxData !== 8'hA5) begin failures++; $display("FAIL a5_data got %h want a5", RxData); end
      checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL a5_ferr got %0d want 0", fe_cnt - fe0); end
      checks++; if (ov_cnt - ov0 !== 0) begin failures++; $display("FAIL a5_oerr got %0d want 0", ov_cnt - ov0); end
      read_pulse();
      checks++; if (RxValid !== 1'b0) begin failures++; $display("FAIL a5_read_clear got %b want 0", RxValid); end
   endtask

   task automatic test_false_start();
      int fe0, ov0;
      fe0 = fe_cnt; ov0 = ov_cnt;
      RxAsync = 1'b0;
      repeat (4) tick_cycle();
      RxAsync = 1'b1;
      repeat (200) tick_cycle();
      checks++; if (RxValid !== 1'b0) begin failures++; $display("FAIL fstart_valid got %b want 0", RxValid); end
      checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL fstart_ferr got %0d want 0", fe_cnt - fe0); end
      checks++; if (ov_cnt - ov0 !== 0) begin failures++; $display("FAIL fstart_oerr got %0d want 0", ov_cnt - ov0); end
   endtask

   task automatic test_frame_err();
      logic vb, va;
      int fe0;
      fe0 = fe_cnt;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 0, vb, va);
      checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL ferr_pulse got %0d want 1", fe_cnt - fe0); end
      checks++; if (RxValid !== 1'b0) begin failures++; $display("FAIL ferr_valid got %b want 0", RxValid); end
   endtask

   task automatic test_overrun();
      logic vb, va;
      int ov0;
      ov0 = ov_cnt;
      send_frame(8'h11, 1'b0, 1'b1, 1'b0, 0, vb, va);
      checks++; if (RxData !== 8'h11) begin failures++; $display("FAIL ovr_first got %h want 11", RxData); end
      send_frame(8'h22, 1'b0, 1'b1, 1'b0, 0, vb, va);
      checks++; if (RxData !== 8'h11) begin failures++; $display("FAIL ovr_keep got %h want 11", RxData); end
      checks++; if (RxValid !== 1'b1) begin failures++; $display("FAIL ovr_valid got %b want 1", RxValid); end
      checks++; if (ov_cnt - ov0 !== 1) begin failures++; $display("FAIL ovr_pulse got %0d want 1", ov_cnt - ov0); end
      read_pulse();
      checks++; if (RxValid !== 1'b0) begin failures++; $display("FAIL ovr_read got %b want 0", RxValid); end
   endtask

   task automatic test_back_to_back();
      logic vb, va;
      int ov0;
      ov0 = ov_cnt;
      send_frame(8'h33, 1'b0, 1'b1, 1'b0, 0, vb, va);
      send_frame(8'h44, 1'b0, 1'b1, 1'b1, 0, vb, va);
      checks++; if (va !== 1'b1) begin failures++; $display("FAIL b2b_valid got %b want 1", va); end
      checks++; if (RxData !== 8'h44) begin failures++; $display("FAIL b2b_data got %h want 44", RxData); end
      checks++; if (ov_cnt - ov0 !== 0) begin failures++; $display("FAIL b2b_oerr got %0d want 0", ov_cnt - ov0); end
   endtask

   // Enters with RxValid=1, RxData=0x44 left unread.
   task automatic test_rx_en();
      int fe0, ov0;
      fe0 = fe_cnt; ov0 = ov_cnt;
      RxAsync = 1'b0;
      repeat (20) tick_cycle();
      RxEn = 1'b0;
      tick_cycle();
      RxEn = 1'b1;
      RxAsync = 1'b1;
      repeat (200) tick_cycle();
      checks++; if (RxValid !== 1'b1) begin failures++; $display("FAIL en_valid got %b want 1", RxValid); end
      checks++; if (RxData !== 8'h44) begin failures++; $display("FAIL en_data got %h want 44", RxData); end
      checks++; if (fe_cnt - fe0 !== 0) begin failures++; $display("FAIL en_ferr got %0d want 0", fe_cnt - fe0); end
      checks++; if (ov_cnt - ov0 !== 0) begin failures++; $display("FAIL en_oerr got %0d want 0", ov_cnt - ov0); end
   endtask

   task automatic test_reset_mid_frame();
      logic vb, va;
      logic [7:0] d;
      int fe0, ov0;
      d = 8'h5A;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(d[i]);
      RxAsync = d[3];
      repeat (8) tick_cycle();
      Rst_n = 1'b0;
      @(negedge Clk);
      checks++; if (RxValid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got %b want 0", RxValid); end
      checks++; if (RxData !== 8'h00) begin failures++; $display("FAIL rstmid_data got %h want 00", RxData); end
      Rst_n = 1'b1;
      RxAsync = 1'b1;
      fe0 = fe_cnt; ov0 = ov_cnt;
      repeat (200) tick_cycle();
      checks++; if (RxValid !== 1'b0) begin failures++; $display("FAIL rstmid_after got %b want 0", RxValid); end
      checks++; if (fe_cnt + ov_cnt - fe0 - ov0 !== 0) begin failures++; $display("FAIL rstmid_pulses got %0d want 0", fe_cnt + ov_cnt - fe0 - ov0); end
      // Clean frame with a tick-less stall mid-frame: counters must freeze.
      send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 37, vb, va);
      checks++; if (va !== 1'b1) begin failures++; $display("FAIL 5a_valid got %b want 1", va); end
      checks++; if (RxData !== 8'h5A) begin failures++; $display("FAIL 5a_data got %h want 5a", RxData); end
      read_pulse();
   endtask

`ifdef UAR_RX_PARITY_EN
   task automatic test_parity();
      logic vb, va;
      int pe0;
      pe0 = pe_cnt;
      send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0, vb, va);
      checks++; if (pe_cnt - pe0 !== 1) begin failures++; $display("FAIL par_bad_pulse got %0d want 1", pe_cnt - pe0); end
      checks++; if (RxValid !== 1'b0) begin failures++; $display("FAIL par_bad_valid got %b want 0", RxValid); end
      pe0 = pe_cnt;
      send_frame(8'h07, 1'b0, 1'b1, 1'b0, 0, vb, va);
      checks++; if (pe_cnt - pe0 !== 0) begin failures++; $display("FAIL par_ok_pulse got %0d want 0", pe_cnt - pe0); end
      checks++; if (RxData !== 8'h07) begin failures++; $display("FAIL par_ok_data got %h want 07", RxData); end
   endtask
`endif

   initial begin
      Rst_n    = 1'b0;
      RxEn     = 1'b1;
      BaudTick = 1'b0;
      RxAsync  = 1'b1;
      RxRead   = 1'b0;
      @(negedge Clk);
      test_reset();
      test_good_frame();
      test_false_start();
      test_frame_err();
      test_overrun();
      test_back_to_back();
      test_rx_en();
      test_reset_mid_frame();
`ifdef UAR_RX_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
